// File: rtl/qsys_param_pio_if.sv
// Avalon-MM slave bus bundle for qsys_param_pio: word address, active-low strobes, 32-bit data.
interface qsys_param_pio_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, read_n, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, read_n, write_n, writedata, output readdata);
endinterface

// File: rtl/qsys_param_pio.sv
// Parametrised Avalon-MM bidirectional PIO: per-bit direction, atomic set/clear of outputs,
// synchronised inputs with edge capture, and a maskable level interrupt.
module qsys_param_pio #(
  parameter int unsigned WIDTH       = 4,
  parameter logic [31:0] DIR_RESET   = '0,
  parameter logic [31:0] OUT_RESET   = '0,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_TYPE   = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  qsys_param_pio_if.slave  bus,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe,
  output logic             irq
);

  typedef enum logic [2:0] {
    REG_DATA   = 3'd0,
    REG_DIR    = 3'd1,
    REG_MASK   = 3'd2,
    REG_EDGE   = 3'd3,
    REG_OUTSET = 3'd4,
    REG_OUTCLR = 3'd5
  } reg_addr_e;

  localparam logic [WIDTH-1:0] DIR_INIT   = DIR_RESET[WIDTH-1:0];
  localparam logic [WIDTH-1:0] OUT_INIT   = OUT_RESET[WIDTH-1:0];
  localparam logic [2:0]       ARM_CYCLES = 3'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] dir;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] sync_ff [SYNC_STAGES];
  logic [WIDTH-1:0] sync_in;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] det;
  logic [WIDTH-1:0] w1c;
  logic [WIDTH-1:0] rd_val;
  logic [2:0]       arm_cnt;
  logic             armed;
  logic             wr;
  logic             rd;
  logic             unused_wdata;

  assign wr           = bus.chipselect & ~bus.write_n;
  assign rd           = bus.chipselect & ~bus.read_n;
  assign wdata        = bus.writedata[WIDTH-1:0];
  assign unused_wdata = ^bus.writedata;

  assign sync_in = sync_ff[SYNC_STAGES-1];
  assign rise    = sync_in & ~prev;
  assign fall    = ~sync_in & prev;
  assign det     = (EDGE_TYPE == 0) ? rise :
                   (EDGE_TYPE == 1) ? fall : (rise | fall);
  assign armed   = (arm_cnt == ARM_CYCLES);
  assign w1c     = (wr && bus.address == REG_EDGE) ? wdata : '0;

  assign out_port = data_out;
  assign oe       = dir;

  always_comb begin
    // NOTE: default first so every path assigns rd_val and no latch is inferred.
    rd_val = '0;
    case (bus.address)
      REG_DATA: rd_val = (dir & data_out) | (~dir & sync_in);
      REG_DIR:  rd_val = dir;
      REG_MASK: rd_val = mask;
      REG_EDGE: rd_val = edge_cap;
      default:  rd_val = '0;
    endcase
  end

  // NOTE: short flop chain, not a RAM, so it is reset to give a known edge history after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_ff[i] <= '0;
      prev <= '0;
    end else begin
      sync_ff[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_ff[i] <= sync_ff[i-1];
      prev <= sync_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out      <= OUT_INIT;
      dir           <= DIR_INIT;
      mask          <= '0;
      edge_cap      <= '0;
      arm_cnt       <= '0;
      irq           <= 1'b0;
      bus.readdata  <= '0;
    end else begin
      // NOTE: non-blocking so all registers see pre-edge values regardless of statement order.
      if (!armed) arm_cnt <= arm_cnt + 3'd1;

      // Set wins over a same-cycle clear; output-direction bits never capture.
      edge_cap <= (edge_cap & ~w1c) | (det & ~dir & {WIDTH{armed}});
      irq      <= |(edge_cap & mask);

      if (rd) bus.readdata <= 32'(rd_val);

      if (wr) begin
        case (bus.address)
          REG_DATA:   data_out <= wdata;
          REG_DIR:    dir      <= wdata;
          REG_MASK:   mask     <= wdata;
          REG_OUTSET: data_out <= data_out | wdata;
          REG_OUTCLR: data_out <= data_out & ~wdata;
          default:    ;
        endcase
      end
    end
  end

endmodule
